// File: rtl/mem_arbiter_pkg.sv
// Shared encodings and bus widths for the data-memory arbiter.
// The round-robin variant is selected by defining MEM_ARB_RR_EN.
package mem_arbiter_pkg;

  localparam int REG_BUS_W = 64;

  localparam int GNT_IFU = 0;
  localparam int GNT_LSU = 1;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2
  } arbState_t;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select between IFU and LSU, one-hot grant out.
// MEM_ARB_RR_EN adds the last-granted pointer input and alternates on conflict.
module mem_arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic       ifuReq,
  input  logic       lsuReq,
`ifdef MEM_ARB_RR_EN
  input  logic       rrPtr,
`endif
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (ifuReq && lsuReq) begin
`ifdef MEM_ARB_RR_EN
      // rrPtr names the last winner, so the other requester goes next
      if (rrPtr == OWN_LSU) begin
        grant[GNT_IFU] = 1'b1;
      end else begin
        grant[GNT_LSU] = 1'b1;
      end
`else
      grant[GNT_LSU] = 1'b1;
`endif
    end else if (lsuReq) begin
      grant[GNT_LSU] = 1'b1;
    end else if (ifuReq) begin
      grant[GNT_IFU] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the data-memory port between IFU (read-only) and LSU, one transaction at a time.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is fixed LSU priority.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = REG_BUS_W,
  parameter int DATA_W = REG_BUS_W,
  parameter int MASK_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifu_req,
  input  logic [ADDR_W-1:0] ifu_addr,
  output logic              ifu_gnt,
  output logic              ifu_rvalid,
  output logic [DATA_W-1:0] ifu_rdata,
  input  logic              lsu_req,
  input  logic              lsu_we,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [MASK_W-1:0] lsu_wmask,
  output logic              lsu_gnt,
  output logic              lsu_rvalid,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [MASK_W-1:0] mem_wmask,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);

  arbState_t         state;
  arbState_t         stateNext;
  owner_t            ownerQ;
  logic              weQ;
  logic [ADDR_W-1:0] addrQ;
  logic [DATA_W-1:0] wdataQ;
  logic [MASK_W-1:0] wmaskQ;
  logic [1:0]        grant;
  logic              respFire;

`ifdef MEM_ARB_RR_EN
  owner_t rrPtr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rrPtr <= OWN_IFU;
    end else if (lsu_gnt) begin
      rrPtr <= OWN_LSU;
    end else if (ifu_gnt) begin
      rrPtr <= OWN_IFU;
    end
  end
`endif

  mem_arb_pick uPick (
    .ifuReq (ifu_req),
    .lsuReq (lsu_req),
`ifdef MEM_ARB_RR_EN
    .rrPtr  (rrPtr),
`endif
    .grant  (grant)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ARB_IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Grants are gated by rst so every output reads 0 while reset is held
  always_comb begin
    stateNext = state;
    ifu_gnt   = 1'b0;
    lsu_gnt   = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (!rst && (grant != 2'b00)) begin
          ifu_gnt   = grant[GNT_IFU];
          lsu_gnt   = grant[GNT_LSU];
          stateNext = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        if (mem_gnt) begin
          stateNext = ARB_WAIT;
        end
      end
      ARB_WAIT: begin
        if (mem_rvalid) begin
          stateNext = ARB_IDLE;
        end
      end
      default: stateNext = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ownerQ <= OWN_IFU;
      weQ    <= 1'b0;
      addrQ  <= '0;
      wdataQ <= '0;
      wmaskQ <= '0;
    end else if (lsu_gnt) begin
      ownerQ <= OWN_LSU;
      weQ    <= lsu_we;
      addrQ  <= lsu_addr;
      wdataQ <= lsu_wdata;
      wmaskQ <= lsu_wmask;
    end else if (ifu_gnt) begin
      ownerQ <= OWN_IFU;
      weQ    <= 1'b0;
      addrQ  <= ifu_addr;
      wdataQ <= '0;
      wmaskQ <= '0;
    end
  end

  assign mem_req   = (state == ARB_ISSUE);
  assign mem_we    = weQ;
  assign mem_addr  = addrQ;
  assign mem_wdata = wdataQ;
  assign mem_wmask = wmaskQ;

  // Responses only count in WAIT; stray ones in IDLE/ISSUE fall through
  assign respFire   = (state == ARB_WAIT) && mem_rvalid;
  assign ifu_rvalid = respFire && (ownerQ == OWN_IFU);
  assign lsu_rvalid = respFire && (ownerQ == OWN_LSU);
  assign ifu_rdata  = ifu_rvalid ? mem_rdata : '0;
  assign lsu_rdata  = lsu_rvalid ? mem_rdata : '0;

endmodule
